alu_bist_sequencer: RTL and testbench

- Hardware stimulus/check engine for the combinational ALU.
- On `start`, drives a fixed table of ALU_operation/operand_A/operand_B vectors into the ALU and samples ALU_result after a settle window.
- Compares each sample against the expected value and reports pass/fail plus the first failing vector.
- Sits beside the ALU in the core's self-test path, as an on-chip power-up/field self-test.

---
 rtl/alu_bist_pkg.sv | 22 ++
 rtl/alu_bist_vectors.sv | 55 +++++
 rtl/alu_bist_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_alu_bist_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// ALU BIST shared definitions.
// Opcodes, FSM encoding and vector-table geometry.
package alu_bist_pkg;

  localparam int ALU_OP_W    = 6;
  localparam int TABLE_DEPTH = 5;
  localparam int TBL_IDX_W   = 3;

  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 6'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SGEU = 6'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 6'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 6'd13;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 6'd14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_bist_vectors.sv
// ALU BIST vector ROM.
// Returns {op, A, B, expected} for a table index.
module alu_bist_vectors
  import alu_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [TBL_IDX_W-1:0]  i_idx,
  output logic [ALU_OP_W-1:0]   o_op,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic [DATA_WIDTH-1:0] o_exp
);

  always_comb begin
    o_op  = '0;
    o_a   = '0;
    o_b   = '0;
    o_exp = '0;
    unique case (1'b1)
      (i_idx == 3'd0): begin
        o_op  = ALU_SUB;
        o_a   = DATA_WIDTH'(32'h2);
        o_b   = DATA_WIDTH'(32'h4);
        o_exp = DATA_WIDTH'(32'hFFFF_FFFE);
      end
      (i_idx == 3'd1): begin
        o_op  = ALU_OR;
        o_a   = DATA_WIDTH'(32'h2);
        o_b   = DATA_WIDTH'(32'h4);
        o_exp = DATA_WIDTH'(32'h6);
      end
      (i_idx == 3'd2): begin
        o_op  = ALU_SRA;
        o_a   = DATA_WIDTH'(32'hA);
        o_b   = DATA_WIDTH'(32'h3);
        o_exp = DATA_WIDTH'(32'h1);
      end
      (i_idx == 3'd3): begin
        o_op  = ALU_SLT;
        o_a   = DATA_WIDTH'(32'h2);
        o_b   = DATA_WIDTH'(32'hFFFF_FFFF);
        o_exp = DATA_WIDTH'(32'h0);
      end
      (i_idx == 3'd4): begin
        o_op  = ALU_SGEU;
        o_a   = DATA_WIDTH'(32'hFFFF_FFFF);
        o_b   = DATA_WIDTH'(32'h4);
        o_exp = DATA_WIDTH'(32'h1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_bist_sequencer.sv
// ALU BIST sequencer.
// Drives table vectors into the ALU and checks results.
module alu_bist_sequencer
  import alu_bist_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_VECTORS   = 5,
  parameter int SETTLE_CYCLES = 1,
  parameter int STOP_ON_FAIL  = 1,
  localparam int IDX_W =
    (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ALU_OP_W-1:0]   ALU_operation,
  output logic [DATA_WIDTH-1:0] operand_A,
  output logic [DATA_WIDTH-1:0] operand_B,
  input  logic [DATA_WIDTH-1:0] ALU_result,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [IDX_W-1:0]      fail_index,
  output logic [DATA_WIDTH-1:0] fail_result
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  if (NUM_VECTORS < 1 || NUM_VECTORS > TABLE_DEPTH) begin : g_bad_nv
    $error("alu_bist_sequencer: NUM_VECTORS out of range");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_bist_sequencer: SETTLE_CYCLES must be >= 1");
  end

  state_t                r_state, w_state;
  logic [IDX_W-1:0]      r_idx, w_idx;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0] r_exp, w_exp;
  logic                  r_fail, w_fail;
  logic [ALU_OP_W-1:0]   r_op, w_op;
  logic [DATA_WIDTH-1:0] r_a, w_a;
  logic [DATA_WIDTH-1:0] r_b, w_b;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  r_pass, w_pass;
  logic [IDX_W-1:0]      r_fidx, w_fidx;
  logic [DATA_WIDTH-1:0] r_fres, w_fres;

  logic [TBL_IDX_W-1:0]  w_rom_idx;
  logic [ALU_OP_W-1:0]   w_rom_op;
  logic [DATA_WIDTH-1:0] w_rom_a;
  logic [DATA_WIDTH-1:0] w_rom_b;
  logic [DATA_WIDTH-1:0] w_rom_exp;
  logic                  w_mismatch;
  logic                  w_last;
  logic                  w_stop;

  // ROM always points at the vector that would be loaded next
  assign w_rom_idx = (r_state == ST_CHECK)
                   ? TBL_IDX_W'(r_idx) + TBL_IDX_W'(1)
                   : '0;

  alu_bist_vectors #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_vectors (
    .i_idx(w_rom_idx),
    .o_op (w_rom_op),
    .o_a  (w_rom_a),
    .o_b  (w_rom_b),
    .o_exp(w_rom_exp)
  );

  assign w_mismatch = (ALU_result != r_exp);
  assign w_last     = (r_idx == IDX_W'(NUM_VECTORS - 1));
  assign w_stop     = w_mismatch && (STOP_ON_FAIL != 0);

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_exp   = r_exp;
    w_fail  = r_fail;
    w_op    = r_op;
    w_a     = r_a;
    w_b     = r_b;
    w_busy  = r_busy;
    w_done  = r_done;
    w_pass  = r_pass;
    w_fidx  = r_fidx;
    w_fres  = r_fres;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state = ST_SETTLE;
          w_idx   = '0;
          w_cnt   = '0;
          w_op    = w_rom_op;
          w_a     = w_rom_a;
          w_b     = w_rom_b;
          w_exp   = w_rom_exp;
          w_fail  = 1'b0;
          w_busy  = 1'b1;
          w_done  = 1'b0;
          w_pass  = 1'b0;
          w_fidx  = '0;
          w_fres  = '0;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          w_state = ST_CHECK;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (w_mismatch && !r_fail) begin
          w_fail = 1'b1;
          w_fidx = r_idx;
          w_fres = ALU_result;
        end
        if (w_stop || w_last) begin
          w_state = ST_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_pass  = !(r_fail || w_mismatch);
        end else begin
          w_state = ST_SETTLE;
          w_idx   = r_idx + IDX_W'(1);
          w_cnt   = '0;
          w_op    = w_rom_op;
          w_a     = w_rom_a;
          w_b     = w_rom_b;
          w_exp   = w_rom_exp;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_fail  <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fidx  <= '0;
      r_fres  <= '0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_exp   <= w_exp;
      r_fail  <= w_fail;
      r_op    <= w_op;
      r_a     <= w_a;
      r_b     <= w_b;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_pass  <= w_pass;
      r_fidx  <= w_fidx;
      r_fres  <= w_fres;
    end
  end

  assign ALU_operation = r_op;
  assign operand_A     = r_a;
  assign operand_B     = r_b;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign fail_index    = r_fidx;
  assign fail_result   = r_fres;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Directed bench for alu_bist_sequencer.
// Edge 1 is the edge that samples start.
module tb_alu_bist_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] alu_model(
    input logic [5:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    r = 32'h0;
    case (op)
      6'd14: r = a - b;
      6'd9:  r = a | b;
      6'd13: r = $unsigned($signed(a) >>> b[4:0]);
      6'd4:  r = {31'd0, $signed(a) < $signed(b)};
      6'd7:  r = {31'd0, a >= b};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Instance 0: defaults (SETTLE=1, STOP_ON_FAIL=1)
  logic        st0 = 1'b0;
  logic [5:0]  op0;
  logic [31:0] a0, b0, res0, fres0;
  logic        busy0, done0, pass0;
  logic [2:0]  fidx0;
  logic        f0_v1 = 1'b0;
  assign res0 = (f0_v1 && op0 == 6'd9) ? 32'h0 : alu_model(op0, a0, b0);

  alu_bist_sequencer u0 (
    .clock(clock), .reset(reset), .start(st0),
    .ALU_operation(op0), .operand_A(a0), .operand_B(b0),
    .ALU_result(res0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_index(fidx0), .fail_result(fres0)
  );

  // Instance 1: STOP_ON_FAIL=0, faults on vectors 1 and 3
  logic        st1 = 1'b0;
  logic [5:0]  op1;
  logic [31:0] a1, b1, res1, fres1;
  logic        busy1, done1, pass1;
  logic [2:0]  fidx1;
  assign res1 = (op1 == 6'd9) ? 32'h0 :
                (op1 == 6'd4) ? 32'h5 : alu_model(op1, a1, b1);

  alu_bist_sequencer #(.STOP_ON_FAIL(0)) u1 (
    .clock(clock), .reset(reset), .start(st1),
    .ALU_operation(op1), .operand_A(a1), .operand_B(b1),
    .ALU_result(res1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_index(fidx1), .fail_result(fres1)
  );

  // Instance 2: SETTLE_CYCLES=3, real ALU
  logic        st2 = 1'b0;
  logic [5:0]  op2;
  logic [31:0] a2, b2, res2, fres2;
  logic        busy2, done2, pass2;
  logic [2:0]  fidx2;
  assign res2 = alu_model(op2, a2, b2);

  alu_bist_sequencer #(.SETTLE_CYCLES(3)) u2 (
    .clock(clock), .reset(reset), .start(st2),
    .ALU_operation(op2), .operand_A(a2), .operand_B(b2),
    .ALU_result(res2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_index(fidx2), .fail_result(fres2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at edge 1 + 1 time unit.
  task automatic pulse(input int which);
    @(negedge clock);
    case (which)
      0: st0 = 1'b1;
      1: st1 = 1'b1;
      default: st2 = 1'b1;
    endcase
    @(posedge clock);
    #1;
    st0 = 1'b0;
    st1 = 1'b0;
    st2 = 1'b0;
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    adv(2);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_op", op0, 0);
    chk("rst_a", a0, 0);
    chk("rst_b", b0, 0);
    chk("rst_fidx", fidx0, 0);
    chk("rst_fres", fres0, 0);
    @(negedge clock);
    reset = 1'b1;

    // Full passing run, defaults
    pulse(0);
    chk("p1_busy_e1", busy0, 1);
    chk("p1_op_e1", op0, 14);
    chk("p1_a_e1", a0, 32'h2);
    chk("p1_b_e1", b0, 32'h4);
    adv(2);
    chk("p1_op_e3", op0, 9);
    adv(7);
    chk("p1_done_e10", done0, 0);
    chk("p1_busy_e10", busy0, 1);
    adv(1);
    chk("p1_done_e11", done0, 1);
    chk("p1_busy_e11", busy0, 0);
    chk("p1_pass", pass0, 1);
    chk("p1_fidx", fidx0, 0);
    chk("p1_fres", fres0, 0);
    chk("p1_op_hold", op0, 7);
    chk("p1_a_hold", a0, 32'hFFFF_FFFF);
    adv(3);
    chk("p1_done_hold", done0, 1);

    // Restart from DONE
    pulse(0);
    chk("p6_done_clr", done0, 0);
    chk("p6_pass_clr", pass0, 0);
    chk("p6_busy", busy0, 1);
    chk("p6_op", op0, 14);
    adv(9);
    chk("p6_done_e10", done0, 0);
    adv(1);
    chk("p6_done_e11", done0, 1);
    chk("p6_pass", pass0, 1);

    // Stop on first fail at vector 1
    f0_v1 = 1'b1;
    pulse(0);
    adv(3);
    chk("p2_done_e4", done0, 0);
    adv(1);
    chk("p2_done_e5", done0, 1);
    chk("p2_busy_e5", busy0, 0);
    chk("p2_pass", pass0, 0);
    chk("p2_fidx", fidx0, 1);
    chk("p2_fres", fres0, 32'h0);
    chk("p2_op_hold", op0, 9);
    f0_v1 = 1'b0;

    // Run-all with two faults on instance 1
    pulse(1);
    adv(9);
    chk("p3_done_e10", done1, 0);
    adv(1);
    chk("p3_done_e11", done1, 1);
    chk("p3_pass", pass1, 0);
    chk("p3_fidx", fidx1, 1);
    chk("p3_fres", fres1, 32'h0);
    chk("p3_op_hold", op1, 7);

    // Reset during SETTLE of vector 2
    pulse(0);
    adv(4);
    chk("p4_op_v2", op0, 13);
    #2;
    reset = 1'b0;
    #1;
    chk("p4_rst_busy", busy0, 0);
    chk("p4_rst_done", done0, 0);
    chk("p4_rst_op", op0, 0);
    chk("p4_rst_a", a0, 0);
    chk("p4_rst_b", b0, 0);
    chk("p4_rst_pass", pass0, 0);
    @(negedge clock);
    reset = 1'b1;
    adv(2);
    chk("p4_idle_busy", busy0, 0);
    chk("p4_idle_done", done0, 0);
    pulse(0);
    adv(9);
    chk("p4_done_e10", done0, 0);
    adv(1);
    chk("p4_done_e11", done0, 1);
    chk("p4_pass", pass0, 1);

    // SETTLE_CYCLES=3 with extra starts while busy
    pulse(2);
    adv(2);
    chk("p5_op_e3", op2, 14);
    @(negedge clock);
    st2 = 1'b1;
    @(posedge clock);
    #1;
    st2 = 1'b0;
    chk("p5_op_e4", op2, 14);
    adv(1);
    chk("p5_op_e5", op2, 9);
    @(negedge clock);
    st2 = 1'b1;
    @(posedge clock);
    #1;
    st2 = 1'b0;
    chk("p5_busy_e6", busy2, 1);
    chk("p5_op_e6", op2, 9);
    adv(14);
    chk("p5_done_e20", done2, 0);
    adv(1);
    chk("p5_done_e21", done2, 1);
    chk("p5_pass", pass2, 1);
    chk("p5_fidx", fidx2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
